uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter between up to eight byte producers. It sits between the producers and the transmitter. It latches the winning byte, strobes the transmitter's falling-edge-triggered start input, and tracks the transmitter's busy flag until the frame completes. It then grants the next requester.

## Interface
- N_REQ, 4, number of requesters (2..8)
- STROBE_CYCLES, 2, cycles tx_int is held high before its falling edge (≥1)
- BUSY_TIMEOUT, 16, cycles allowed after strobe for tx_busy to rise (≥4)
- GAP_CYCLES, 2, idle cycles inserted after tx_busy falls, before next grant (0..255)
- clk  in  1  system clock; one clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req  in  N_REQ  per-requester byte-valid level
- req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i]
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted
- tx_data  out  8  byte presented to transmitter, stable from strobe to frame end
- tx_int  out  1  transmitter start strobe; falling edge starts the frame
- tx_busy  in  1  transmitter busy flag, high for the whole frame
- grant_id  out  3  index of the current/last granted requester
- busy  out  1  high whenever state ≠ IDLE
- err_timeout  out  1  one-cycle pulse: tx_busy never rose after strobe

## Operation
- States: IDLE, STROBE, WAIT_BUSY, WAIT_DONE, GAP.
- Round-robin pointer ptr (3 bits, range 0..N_REQ-1). The winner is the first set req bit scanning ptr, ptr+1, … with wrap at N_REQ-1→0.
- IDLE, any req set, in a single cycle:
  - tx_data←req_data[winner], grant_id←winner, ack[winner]←1, tx_int←1.
  - ptr←winner+1, with N_REQ wrapping to 0.
  - Strobe counter cleared; →STROBE.
- IDLE, no req: outputs hold. ack=0, tx_int=0.
- STROBE:
  - tx_int stays high for STROBE_CYCLES cycles in total, counting the entry cycle.
  - Then tx_int←0, timeout counter cleared; →WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise the counter increments. At BUSY_TIMEOUT-1: err_timeout pulse, →IDLE. The byte is dropped; no retry.
- WAIT_DONE: tx_busy=0 → GAP, gap counter cleared. If GAP_CYCLES=0, go straight to IDLE.
- GAP: count GAP_CYCLES cycles, then →IDLE.
- Requests:
  - A requester holds req and req_data until it sees ack.
  - req still high in the cycle after ack is a new request. It is served only when round-robin order reaches it again.
  - req may drop at any time before ack; it is simply not granted.
  - req changes outside IDLE are ignored.
- Only one ack bit is ever high at a time. At most one ack occurs per frame.
- tx_data changes only in the IDLE grant cycle.

## Timing
- Reset (rst_n low at a posedge) forces, at the next edge:
  - state=IDLE, ptr=0, ack=0, tx_data=8'h00, tx_int=0, grant_id=0, busy=0, err_timeout=0.
  - All counters are cleared.
- Reset mid-frame abandons the frame immediately. tx_int drops low within that same edge; the transmitter may see a spurious falling edge, which is accepted.
- Arbitration latency:
  - req sampled at edge t → ack, tx_int rise and tx_data valid after edge t.
  - tx_int falls after edge t+STROBE_CYCLES.
- Grant-to-grant minimum is STROBE_CYCLES + 1 (busy rise) + frame length + 1 + GAP_CYCLES + 1 (IDLE) cycles.
- Simultaneous events:
  - tx_busy rising on the same edge the timeout count hits: busy wins, no error.
  - tx_busy already high on entry to WAIT_BUSY: leave on the first cycle.
- busy is registered and equals (state ≠ IDLE).

## Test plan
- Single requester: N_REQ=4, req=4'b0100, req_data[23:16]=8'hA5. Required response:
  - ack=4'b0100 for exactly 1 cycle.
  - tx_data=8'hA5, grant_id=2, tx_int high 2 cycles.
  - Model raises tx_busy 3 cycles after the tx_int fall, holds it 100 cycles, then drops it. busy returns low 2+1 cycles after the fall.
- Round-robin fairness: all four req held high continuously with distinct bytes 8'h10..8'h13 → grant_id sequence 0,1,2,3,0 and tx_data 10,11,12,13,10. Each ack is a single-cycle pulse; there are never two concurrent acks.
- Pointer wrap/skip: ptr=3 after a grant to 2; req=4'b0011 → grant 0, then 1. With req=4'b1001 and ptr=1 → grant 3 first.
- Timeout: req[1]=1 while the model holds tx_busy=0 →
  - err_timeout pulses once, 16 cycles after entering WAIT_BUSY; state returns to IDLE.
  - A still-held req[1] is granted again on the next IDLE cycle.
- Reset mid-frame: rst_n=0 for 1 cycle during WAIT_DONE →
  - next edge: tx_int=0, busy=0, tx_data=00, grant_id=0, ptr=0.
  - A held req[3] after reset is granted with a fresh ack.
- Late busy vs timeout: tx_busy rises exactly at timeout count 15 → no err_timeout, and the frame completes normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART byte transmitter among N_REQ
//   byte producers. It latches the winning byte, strobes the transmitter's
//   falling-edge start input, and follows tx_busy to the end of the frame.
//   After an optional idle gap it grants the next requester.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   req[i]        : requester i has a byte pending (held until ack[i])
//   req_data      : byte of requester i on bits [8i+7:8i]
//   ack[i]        : one-cycle pulse, byte of requester i accepted
//   tx_data       : byte presented to the transmitter
//   tx_int        : start strobe; its falling edge starts the frame
//   tx_busy       : transmitter busy flag
//   grant_id      : index of the current/last granted requester
//   busy          : high whenever the sequencer is not idle
//   err_timeout   : one-cycle pulse, tx_busy never rose after the strobe
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int BUSY_TIMEOUT  = 16,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           tx_data,
    output logic                 tx_int,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    // One counter is shared by STROBE, WAIT_BUSY and GAP; size it for the
    // longest of the three.
    localparam int M1      = (STROBE_CYCLES > BUSY_TIMEOUT) ? STROBE_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_MAX = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, STROBE, WAIT_BUSY, WAIT_DONE, GAP
    } state_t;

    state_t           state, state_d;
    logic [2:0]       ptr, ptr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [N_REQ-1:0] ack_d;
    logic [7:0]       tx_data_d;
    logic             tx_int_d;
    logic [2:0]       grant_d;
    logic             err_d;

    // Winner search: lowest set req at or above ptr, otherwise lowest set
    // req overall (this is the wrap-around part of the scan).
    logic       found_hi, found_lo, found;
    logic [2:0] win_hi, win_lo, winner;
    logic [7:0] win_data;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = 3'd0;
        win_lo   = 3'd0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                found_lo = 1'b1;
                win_lo   = 3'(j);
                if (j >= int'(ptr)) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(j);
                end
            end
        end
        found  = found_hi | found_lo;
        winner = found_hi ? win_hi : win_lo;

        win_data = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == winner) win_data = req_data[8*j +: 8];
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        cnt_d     = cnt;
        ack_d     = '0;
        tx_data_d = tx_data;
        tx_int_d  = tx_int;
        grant_d   = grant_id;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                tx_int_d = 1'b0;
                if (found) begin
                    tx_data_d = win_data;
                    grant_d   = winner;
                    tx_int_d  = 1'b1;
                    for (int j = 0; j < N_REQ; j++) begin
                        ack_d[j] = (3'(j) == winner);
                    end
                    ptr_d   = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
                    cnt_d   = '0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                // Entry cycle counts as the first strobe cycle.
                if (cnt == CW'(STROBE_CYCLES - 1)) begin
                    tx_int_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = WAIT_BUSY;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_BUSY: begin
                // tx_busy takes priority over a timeout on the same edge.
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            cnt         <= '0;
            ack         <= '0;
            tx_data     <= 8'h00;
            tx_int      <= 1'b0;
            grant_id    <= 3'd0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            ack         <= ack_d;
            tx_data     <= tx_data_d;
            tx_int      <= tx_int_d;
            grant_id    <= grant_d;
            busy        <= (state_d != IDLE);
            err_timeout <= err_d;
        end
    end

endmodule
